// File: rtl/ov7670_sccb_config_sequencer.sv
// -----------------------------------------------------------------------------
// ov7670_sccb_config_sequencer
//
// Walks the OV7670 configuration LUT ({reg_addr, value} per entry) and issues
// one SCCB transaction per entry to a shared byte master over a req/done
// handshake. The leading READ_ENTRIES entries are ID reads whose returned byte
// must match the LUT value byte; the rest are register writes. A settle delay
// is inserted after power-up/restart and after a soft-reset write (reg 0x12,
// bit7 set). NACKed transactions are retried up to MAX_RETRY times.
//
// Ports:
//   iCLK, iRST_N        clock, asynchronous active-low reset
//   i_start             restart pulse, honoured only once done or errored
//   LUT_INDEX/LUT_DATA  LUT address out, combinational LUT entry in
//   o_req/o_rd/o_addr/o_wdata   transaction request to the SCCB master
//   i_done/i_nack/i_rdata       completion pulse, NACK flag and read byte
//   o_busy/o_cfg_done/o_cfg_err status to the capture pipeline
//   o_err_index         LUT index of the entry that caused the error
// -----------------------------------------------------------------------------
module ov7670_sccb_config_sequencer #(
  parameter int LUT_SIZE      = 187,
  parameter int READ_ENTRIES  = 2,
  parameter int POWERUP_DELAY = 1_250_000,
  parameter int RESET_DELAY   = 125_000,
  parameter int MAX_RETRY     = 3
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        i_start,
  output logic [7:0]  LUT_INDEX,
  input  logic [15:0] LUT_DATA,
  output logic        o_req,
  output logic        o_rd,
  output logic [7:0]  o_addr,
  output logic [7:0]  o_wdata,
  input  logic        i_done,
  input  logic        i_nack,
  input  logic [7:0]  i_rdata,
  output logic        o_busy,
  output logic        o_cfg_done,
  output logic        o_cfg_err,
  output logic [7:0]  o_err_index
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [20:0] PWR_LAST  = 21'(POWERUP_DELAY - 1);
  localparam logic [20:0] RST_LAST  = 21'(RESET_DELAY - 1);
  localparam logic [7:0]  LAST_IDX  = 8'(LUT_SIZE - 1);
  localparam logic [7:0]  RD_LIMIT  = 8'(READ_ENTRIES);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PWR, S_FETCH, S_REQ, S_RST, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t        state, state_next;
  logic [20:0]   dly_cnt;
  logic [RW-1:0] retry;

  // Transaction outcome, evaluated only while a done pulse is seen in S_REQ.
  logic can_retry, id_mismatch, soft_rst, last_entry;

  assign can_retry   = (retry < RETRY_MAX);
  assign id_mismatch = o_rd && (i_rdata != o_wdata);
  assign soft_rst    = !o_rd && (o_addr == 8'h12) && o_wdata[7];
  assign last_entry  = (LUT_INDEX == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= S_PWR;
    else         state <= state_next;
  end

  // NOTE: next state gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_PWR:   if (dly_cnt == PWR_LAST) state_next = S_FETCH;
      S_FETCH: state_next = S_REQ;
      S_REQ: begin
        if (i_done) begin
          if (i_nack)           state_next = can_retry ? S_FETCH : S_ERR;
          else if (id_mismatch) state_next = S_ERR;
          else if (soft_rst)    state_next = S_RST;
          else                  state_next = S_NEXT;
        end
      end
      S_RST:   if (dly_cnt == RST_LAST) state_next = S_NEXT;
      S_NEXT:  state_next = last_entry ? S_DONE : S_FETCH;
      S_DONE,
      S_ERR:   if (i_start) state_next = S_PWR;
      default: state_next = S_PWR;
    endcase
  end

  // Datapath registers. The delay counter counts cycles spent in the current
  // state and restarts at zero on every state change, which gives both the
  // power-up and the soft-reset settle windows without separate clears.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      dly_cnt     <= '0;
      LUT_INDEX   <= '0;
      o_rd        <= 1'b0;
      o_addr      <= '0;
      o_wdata     <= '0;
      retry       <= '0;
      o_err_index <= '0;
    end else begin
      dly_cnt <= (state_next != state) ? 21'd0 : dly_cnt + 21'd1;

      unique case (state)
        S_FETCH: begin
          o_addr  <= LUT_DATA[15:8];
          o_wdata <= LUT_DATA[7:0];
          o_rd    <= (LUT_INDEX < RD_LIMIT);
        end
        S_REQ: begin
          if (i_done) begin
            if (i_nack) begin
              if (can_retry) retry       <= retry + RW'(1);
              else           o_err_index <= LUT_INDEX;
            end else if (id_mismatch) begin
              o_err_index <= LUT_INDEX;
            end else begin
              retry <= '0;
            end
          end
        end
        S_NEXT: if (!last_entry) LUT_INDEX <= LUT_INDEX + 8'd1;
        S_DONE,
        S_ERR: begin
          if (i_start) begin
            retry     <= '0;
            LUT_INDEX <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and status decode straight from state, so an asynchronous
  // reset drops o_req immediately and abandons any outstanding request.
  assign o_req      = (state == S_REQ);
  assign o_cfg_done = (state == S_DONE);
  assign o_cfg_err  = (state == S_ERR);
  assign o_busy     = !(o_cfg_done || o_cfg_err);

endmodule

// File: tb/tb_ov7670_sccb_config_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ov7670_sccb_config_sequencer
//
// Self-checking bench: small LUT, SCCB master model answering 3 cycles after
// each request with programmable NACK/read-byte faults, a table of whole-run
// scenarios and hand-written sequences for latency, soft-reset gaps, restart
// and asynchronous reset mid-request.
// -----------------------------------------------------------------------------
module tb_ov7670_sccb_config_sequencer;

  logic        iCLK;
  logic        iRST_N;
  logic        i_start;
  logic [7:0]  LUT_INDEX;
  logic [15:0] LUT_DATA;
  logic        o_req, o_rd;
  logic [7:0]  o_addr, o_wdata;
  logic        i_done, i_nack;
  logic [7:0]  i_rdata;
  logic        o_busy, o_cfg_done, o_cfg_err;
  logic [7:0]  o_err_index;

  ov7670_sccb_config_sequencer #(
    .LUT_SIZE(6), .READ_ENTRIES(2), .POWERUP_DELAY(8),
    .RESET_DELAY(4), .MAX_RETRY(2)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .i_start(i_start),
    .LUT_INDEX(LUT_INDEX), .LUT_DATA(LUT_DATA),
    .o_req(o_req), .o_rd(o_rd), .o_addr(o_addr), .o_wdata(o_wdata),
    .i_done(i_done), .i_nack(i_nack), .i_rdata(i_rdata),
    .o_busy(o_busy), .o_cfg_done(o_cfg_done), .o_cfg_err(o_cfg_err),
    .o_err_index(o_err_index)
  );

  function automatic logic [15:0] lut_val(input logic [7:0] idx);
    case (idx)
      8'd0:    lut_val = 16'h1C7F;
      8'd1:    lut_val = 16'h1DA2;
      8'd2:    lut_val = 16'h1280;
      8'd3:    lut_val = 16'h40D0;
      8'd4:    lut_val = 16'h3A04;
      8'd5:    lut_val = 16'h1240;
      default: lut_val = 16'h0000;
    endcase
  endfunction

  assign LUT_DATA = lut_val(LUT_INDEX);

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int cyc = 0;
  initial forever begin
    @(posedge iCLK);
    cyc++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // ---------------- master model + transaction log ----------------
  int nack_idx = -1, nack_left = 0, bad_idx = -1, bad_val = 0;
  int ntx = 0;
  logic [7:0] log_addr [64];
  logic       log_rd   [64];
  logic [7:0] log_wd   [64];
  int         t_req    [64];
  int         t_done   [64];

  initial begin
    int m_cnt;
    logic m_prev;
    logic [15:0] ent;
    int idx;
    i_done = 1'b0; i_nack = 1'b0; i_rdata = 8'h00;
    m_cnt = 0; m_prev = 1'b0;
    forever begin
      @(negedge iCLK);
      if (!iRST_N) begin
        i_done = 1'b0; i_nack = 1'b0; m_cnt = 0; m_prev = 1'b0;
      end else begin
        if (i_done) begin
          i_done = 1'b0; i_nack = 1'b0;
        end
        if (o_req && !m_prev && ntx < 64) begin
          log_addr[ntx] = o_addr;
          log_rd[ntx]   = o_rd;
          log_wd[ntx]   = o_wdata;
          t_req[ntx]    = cyc;
          ntx++;
          m_cnt = 0;
        end
        m_prev = o_req;
        if (o_req) begin
          m_cnt++;
          if (m_cnt == 3) begin
            i_done = 1'b1;
            idx = int'(LUT_INDEX);
            if (idx == nack_idx && nack_left > 0) begin
              i_nack = 1'b1;
              nack_left--;
            end
            ent = lut_val(LUT_INDEX);
            i_rdata = (idx == bad_idx) ? 8'(bad_val) : ent[7:0];
            if (ntx > 0) t_done[ntx-1] = cyc;
          end
        end else begin
          m_cnt = 0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic start_run(input int nk_idx, input int nk_n,
                           input int b_idx, input int b_val, input bit chk_rst);
    @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    nack_idx = nk_idx; nack_left = nk_n; bad_idx = b_idx; bad_val = b_val;
    ntx = 0;
    if (chk_rst) begin
      check("rst_o_req", o_req, 0);
      check("rst_o_busy", o_busy, 1);
      check("rst_cfg_done", o_cfg_done, 0);
      check("rst_cfg_err", o_cfg_err, 0);
      check("rst_lut_index", LUT_INDEX, 0);
      check("rst_o_rd", o_rd, 0);
      check("rst_o_addr", o_addr, 0);
      check("rst_o_wdata", o_wdata, 0);
      check("rst_err_index", o_err_index, 0);
    end
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  task automatic measure_first_req(input string name);
    int n = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge iCLK);
      #1;
      n++;
      if (o_req) break;
    end
    check(name, n, 9);
    check({name, "_addr"}, o_addr, 8'h1C);
  endtask

  task automatic run_until_end(output int t_end);
    bit seen = 0;
    t_end = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge iCLK);
      if (o_cfg_done || o_cfg_err) begin
        seen = 1;
        t_end = cyc;
        break;
      end
    end
    if (!seen) check("run_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    @(negedge iCLK);
    i_start = 1'b1;
    @(negedge iCLK);
    i_start = 1'b0;
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    int   nack_idx; int nack_n; int bad_idx; int bad_val;
    logic exp_done; logic exp_err; int exp_eidx;
    int   exp_ntx;  int exp_nwr;  int exp_n40;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int t_end, nwr, n40;
    logic [15:0] e;

    iRST_N = 1'b0; i_start = 1'b0;

    //            nk  n  bad  val   done err eidx ntx nwr n40
    vecs[0] = '{-1, 0, -1, 0,    1'b1, 1'b0, 0, 6, 4, 1};  // nominal
    vecs[1] = '{ 3, 2, -1, 0,    1'b1, 1'b0, 0, 8, 6, 3};  // two NACKs then ACK
    vecs[2] = '{ 4, 3, -1, 0,    1'b0, 1'b1, 4, 7, 5, 1};  // retries exhausted
    vecs[3] = '{-1, 0,  1, 8'h55, 1'b0, 1'b1, 1, 2, 0, 0}; // ID mismatch entry 1
    vecs[4] = '{-1, 0,  0, 8'h00, 1'b0, 1'b1, 0, 1, 0, 0}; // ID mismatch entry 0
    vecs[5] = '{ 0, 2, -1, 0,    1'b1, 1'b0, 0, 8, 4, 1};  // NACKed read retried

    for (int v = 0; v < 6; v++) begin
      start_run(vecs[v].nack_idx, vecs[v].nack_n, vecs[v].bad_idx, vecs[v].bad_val, 1'b0);
      run_until_end(t_end);
      repeat (20) @(negedge iCLK);  // no further requests may follow
      nwr = 0; n40 = 0;
      for (int k = 0; k < ntx; k++) begin
        if (!log_rd[k]) nwr++;
        if (log_addr[k] == 8'h40 && log_wd[k] == 8'hD0) n40++;
      end
      check($sformatf("v%0d_done", v), o_cfg_done, vecs[v].exp_done);
      check($sformatf("v%0d_err", v), o_cfg_err, vecs[v].exp_err);
      check($sformatf("v%0d_busy", v), o_busy, 0);
      check($sformatf("v%0d_err_index", v), o_err_index, vecs[v].exp_eidx);
      check($sformatf("v%0d_ntx", v), ntx, vecs[v].exp_ntx);
      check($sformatf("v%0d_nwr", v), nwr, vecs[v].exp_nwr);
      check($sformatf("v%0d_n40", v), n40, vecs[v].exp_n40);
    end

    // ---- nominal: reset state, first-request latency, order, gaps ----
    start_run(-1, 0, -1, 0, 1'b1);
    measure_first_req("first_req_latency");
    run_until_end(t_end);
    check("nom_ntx", ntx, 6);
    for (int k = 0; k < 6; k++) begin
      e = lut_val(8'(k));
      check($sformatf("nom_addr%0d", k), log_addr[k], e[15:8]);
      check($sformatf("nom_wdata%0d", k), log_wd[k], e[7:0]);
      check($sformatf("nom_rd%0d", k), log_rd[k], (k < 2) ? 1 : 0);
    end
    // Normal done->next req gap is 3 cycles; soft reset adds 4 more.
    check("gap_after_softrst", t_req[3] - t_done[2], 7);
    check("gap_after_entry3", t_req[4] - t_done[3], 3);
    check("gap_after_entry4", t_req[5] - t_done[4], 3);
    check("entry5_no_delay", t_end - t_done[5], 2);
    check("nom_done", o_cfg_done, 1);

    // ---- exhaustion, then i_start rerun; a mid-run i_start is ignored ----
    start_run(4, 3, -1, 0, 1'b0);
    run_until_end(t_end);
    check("exh_err", o_cfg_err, 1);
    check("exh_err_index", o_err_index, 4);
    check("exh_ntx", ntx, 7);
    #1;
    ntx = 0;
    pulse_start();
    check("restart_busy", o_busy, 1);
    check("restart_err_clr", o_cfg_err, 0);
    for (int k = 0; k < 200; k++) begin
      @(negedge iCLK);
      if (o_req && LUT_INDEX == 8'd2) break;
    end
    pulse_start();  // busy: must be ignored
    run_until_end(t_end);
    check("rerun_done", o_cfg_done, 1);
    check("rerun_err", o_cfg_err, 0);
    check("rerun_ntx", ntx, 6);

    // ---- asynchronous reset while entry 3 is requested ----
    start_run(-1, 0, -1, 0, 1'b0);
    for (int k = 0; k < 200; k++) begin
      @(negedge iCLK);
      if (o_req && LUT_INDEX == 8'd3) break;
    end
    check("midrst_pre_req", o_req, 1);
    #1;
    iRST_N = 1'b0;
    #1;
    check("midrst_req_drop", o_req, 0);
    check("midrst_index", LUT_INDEX, 0);
    check("midrst_busy", o_busy, 1);
    ntx = 0;
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b1;
    measure_first_req("midrst_latency");
    run_until_end(t_end);
    check("midrst_done", o_cfg_done, 1);
    check("midrst_ntx", ntx, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
